next_uart_tx: RTL
=================

// Module: next_uart_tx
// PURPOSE
//   8N1 UART transmitter that consumes the UART send strobe and the low byte of the UART I/O data
//   register produced by the memory/IO stage, and serialises that byte onto the tx pin.
//   Returns busy to the memory/IO stage (io_uart_tx_busy) for software polling via the UART CSR.
//   Sits directly downstream of the memory-mapped IO block, between it and the board pin.
// PARAMETERS
//   CLKS_PER_BIT  104  clk cycles per UART bit period; legal range 2..65535
//   CNT_W         16   width of baud counter; must hold CLKS_PER_BIT-1
// PORTS
//   clk    in   1  system clock; all state on rising edge
//   rst_n  in   1  asynchronous active-low reset
//   send   in   1  start request (io_uart_send); level-sampled only in IDLE
//   data   in   8  byte to send (io_uart_io_reg[7:0]); captured on accept
//   tx     out  1  serial line, idle high
//   busy   out  1  high from cycle after accept until frame complete (io_uart_tx_busy)
//   done   out  1  one-cycle pulse on last cycle of stop bit
// BEHAVIOUR
//   - Reset (rst_n low, any time, incl. mid-frame): state=IDLE, tx=1, busy=0, done=0,
//     baud counter=0, bit index=0, shift reg=0. Frame in flight is abandoned; no partial stop bit.
//   - All outputs registered. States: IDLE, START, DATA, [PARITY], STOP.
//   - IDLE: tx=1, busy=0. If send=1 at a clk edge: data latched into shift reg, state->START,
//     counter=0. busy and tx=0 appear the cycle after the accept edge (latency 1).
//   - Each non-IDLE state lasts exactly CLKS_PER_BIT cycles; counter counts 0..CLKS_PER_BIT-1,
//     advancing state and clearing to 0 on terminal count.
//   - START: tx=0. -> DATA, bit index=0.
//   - DATA: tx=shift[0], LSB first; shift right each bit; bit index 0..7; after index 7 ->
//     STOP (or PARITY if enabled).
//   - STOP: tx=1. On terminal count: done=1 for that cycle, state->IDLE; busy drops next cycle.
//   - Frame length: 10*CLKS_PER_BIT cycles (11* with parity) from first tx=0 cycle to busy low.
//   - send while not IDLE: ignored, no queueing; data changes mid-frame have no effect.
//   - send held high: a new frame is accepted on the first IDLE cycle, giving exactly one idle
//     (tx=1, busy=0) cycle between frames.
//   - send and rst_n low simultaneously: reset wins; nothing accepted.
//   - Counter arithmetic unsigned CNT_W bits; never wraps (cleared at CLKS_PER_BIT-1).
// CONFIGURATION
//   UART_TX_PARITY_EN defined: PARITY state inserted after DATA, tx = ^data_latched (even parity),
//     one bit period; frame 11 bits (8E1).
//   UART_TX_PARITY_EN undefined: no PARITY state or logic; DATA -> STOP directly; frame 8N1.
// TESTING (CLKS_PER_BIT=4 unless stated)
//   1 Reset: rst_n=0 for 3 cycles, send=1 -> tx=1, busy=0, done=0 throughout; no frame after
//     rst_n release until send is sampled in IDLE.
//   2 send pulse 1 cycle, data=0x55 -> busy=1 next cycle; tx bit sequence 0,1,0,1,0,1,0,1,0,1
//     each held 4 cycles; done pulse on cycle 40; busy=0 on cycle 41.
//   3 Mid-frame send=1, data=0xFF during DATA of a 0xA3 frame -> tx carries 0xA3 only
//     (1,1,0,0,0,1,0,1 LSB first); no second frame starts.
//   4 send held high, data=0x00 -> two back-to-back frames, exactly 1 idle cycle between done and
//     next start bit; all 8 data bits low.
//   5 Assert rst_n=0 during data bit 3 of 0x0F -> tx=1, busy=0 asynchronously; after release
//     line stays idle.
//   6 UART_TX_PARITY_EN defined, data=0x07 -> parity bit=1 after bit 7, frame 44 cycles;
//     data=0x03 -> parity bit=0.

Source files
------------

// File: rtl/next_uart_tx_if.sv
// Send/busy/done handshake between the memory/IO stage and the UART
// transmitter; master is the IO block, slave is next_uart_tx.
interface next_uart_tx_if;
   logic       send;
   logic [7:0] data;
   logic       busy;
   logic       done;

   modport master (
      output send,
      output data,
      input  busy,
      input  done
   );

   modport slave (
      input  send,
      input  data,
      output busy,
      output done
   );
endinterface

// File: rtl/next_uart_tx.sv
// 8N1 UART transmitter fed by the IO stage send strobe and data byte.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1).
module next_uart_tx #(
   parameter int CLKS_PER_BIT = 104,
   parameter int CNT_W        = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   next_uart_tx_if.slave  io,
   output logic           tx
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(CLKS_PER_BIT - 1);

   logic [2:0]       state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       idx, idx_n;
   logic [7:0]       shift, shift_n;
   logic             tx_n;
   logic             busy, done;
   logic             done_n;
   logic             last;
`ifdef UART_TX_PARITY_EN
   logic             par, par_n;
`endif

   assign last    = (cnt == CNT_LAST);
   assign io.busy = busy;
   assign io.done = done;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      shift_n = shift;
`ifdef UART_TX_PARITY_EN
      par_n   = par;
`endif
      if (state != S_IDLE)
         cnt_n = last ? '0 : cnt + 1'b1;
      unique case (1'b1)
         (state == S_IDLE): begin
            if (io.send) begin
               shift_n = io.data;
`ifdef UART_TX_PARITY_EN
               par_n   = ^io.data;
`endif
               state_n = S_START;
               cnt_n   = '0;
               idx_n   = '0;
            end
         end
         (state == S_START): begin
            if (last) begin
               state_n = S_DATA;
               idx_n   = '0;
            end
         end
         (state == S_DATA): begin
            if (last) begin
               shift_n = {1'b0, shift[7:1]};
               if (idx == 3'd7) begin
                  idx_n = '0;
`ifdef UART_TX_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  idx_n = idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         (state == S_PARITY): begin
            if (last)
               state_n = S_STOP;
         end
`endif
         (state == S_STOP): begin
            if (last)
               state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
            cnt_n   = '0;
            idx_n   = '0;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line
   // up with the state they describe, one cycle after accept.
   always_comb begin
      tx_n = 1'b1;
      unique case (1'b1)
         (state_n == S_START): tx_n = 1'b0;
         (state_n == S_DATA):  tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
         (state_n == S_PARITY): tx_n = par_n;
`endif
         default:              tx_n = 1'b1;
      endcase
      done_n = (state_n == S_STOP) && (cnt_n == CNT_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         idx   <= '0;
         shift <= '0;
         tx    <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         shift <= shift_n;
         tx    <= tx_n;
         busy  <= (state_n != S_IDLE);
         done  <= done_n;
`ifdef UART_TX_PARITY_EN
         par   <= par_n;
`endif
      end
   end

endmodule
